play_judge: RTL and testbench

- Multi-lane timing judge for play mode.
- Accepts a time-ordered stream of chart goals (lane, target time, last flag) from the song sequencer through a valid/ready handshake, and buffers them in a small FIFO.
- Grades player hits against the head goal as PERFECT, GOOD or MISS using parametrised timing windows.
- Maintains combo, max combo, per-grade counts and a saturating score for the scoreboard.

---
 rtl/play_judge_pkg.sv | 23 ++
 rtl/play_judge_if.sv | 28 ++
 rtl/play_judge_fifo.sv | 59 +++++
 rtl/play_judge.sv | 228 ++++++++++++++++++++++
 tb/tb_play_judge.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/play_judge_pkg.sv
// Shared types and constants for the play-mode timing judge.
// Grade encoding, score constants and FSM states.
package play_judge_pkg;

    typedef enum logic [1:0] {
        GRADE_NONE    = 2'd0,
        GRADE_PERFECT = 2'd1,
        GRADE_GOOD    = 2'd2,
        GRADE_MISS    = 2'd3
    } grade_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int BASE_PERFECT = 300;
    localparam int BASE_GOOD    = 100;
    localparam int BASE_MISS    = 0;
    localparam int BONUS_CAP    = 100;

endpackage

// File: rtl/play_judge_if.sv
// Goal handshake between the song sequencer (master)
// and the judge (slave).
interface play_judge_if #(
    parameter int LANE_BITS  = 3,
    parameter int CLOCK_BITS = 20
);
    logic                  goal_valid;
    logic                  goal_ready;
    logic [LANE_BITS-1:0]  goal_lane;
    logic [CLOCK_BITS-1:0] goal_time;
    logic                  goal_last;

    modport master (
        output goal_valid,
        output goal_lane,
        output goal_time,
        output goal_last,
        input  goal_ready
    );

    modport slave (
        input  goal_valid,
        input  goal_lane,
        input  goal_time,
        input  goal_last,
        output goal_ready
    );
endinterface

// File: rtl/play_judge_fifo.sv
// Small synchronous FIFO of pending goals {lane, time}.
// Push while full is accepted only together with a pop.
module judge_fifo #(
    parameter int LANE_BITS  = 3,
    parameter int CLOCK_BITS = 20,
    parameter int DEPTH      = 4,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [LANE_BITS-1:0]  in_lane,
    input  logic [CLOCK_BITS-1:0] in_time,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count,
    output logic [LANE_BITS-1:0]  head_lane,
    output logic [CLOCK_BITS-1:0] head_time
);
    logic [LANE_BITS-1:0]  lane_mem [DEPTH];
    logic [CLOCK_BITS-1:0] time_mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full      = count == CW'(DEPTH);
    assign empty     = count == '0;
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_lane = lane_mem[rd_ptr];
    assign head_time = time_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            lane_mem[wr_ptr] <= in_lane;
            time_mem[wr_ptr] <= in_time;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/play_judge.sv
// Multi-lane timing judge: grades hits against the head goal
// and keeps combo, per-grade counts and a saturating score.
module play_judge
    import play_judge_pkg::*;
#(
    parameter int LANES       = 7,
    parameter int LANE_BITS   = 3,
    parameter int CLOCK_BITS  = 20,
    parameter int DEPTH       = 4,
    parameter int PERFECT_WIN = 8,
    parameter int GOOD_WIN    = 24,
    parameter int SCORE_BITS  = 21,
    parameter int COMBO_BITS  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  strict,
    input  logic                  tick,
    play_judge_if.slave           goal,
    input  logic [LANES-1:0]      hit,
    output logic [CLOCK_BITS-1:0] now,
    output logic                  judge_valid,
    output logic [1:0]            judge_grade,
    output logic [LANE_BITS-1:0]  judge_lane,
    output logic [SCORE_BITS-1:0] score,
    output logic [COMBO_BITS-1:0] combo,
    output logic [COMBO_BITS-1:0] max_combo,
    output logic [COMBO_BITS-1:0] perfect_cnt,
    output logic [COMBO_BITS-1:0] good_cnt,
    output logic [COMBO_BITS-1:0] miss_cnt,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t                state;
    logic                  strict_q;
    logic                  last_seen;
    logic [LANES-1:0]      hit_pend;

    logic                  full;
    logic                  empty;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         count_after;
    logic [LANE_BITS-1:0]  head_lane;
    logic [CLOCK_BITS-1:0] head_time;

    logic                  run;
    logic                  restart;
    logic                  flush;
    logic                  push;
    logic                  pop;
    logic                  last_next;
    logic                  stray;
    logic [LANES-1:0]      hit_eff;
    logic [LANES-1:0]      lane_mask;
    logic [LANES-1:0]      consume;
    logic [LANES-1:0]      unconsumed;
    logic                  head_hit;
    logic [CLOCK_BITS:0]   d;
    logic [CLOCK_BITS:0]   abs_d;
    logic                  in_perf;
    logic                  in_good;
    logic                  late;
    grade_t                grade;

    logic [SCORE_BITS:0]   base;
    logic [SCORE_BITS:0]   bonus;
    logic [SCORE_BITS:0]   sum;
    logic [SCORE_BITS-1:0] score_next;
    logic [COMBO_BITS-1:0] combo_inc;

    function automatic logic [COMBO_BITS-1:0] sat_inc(
        input logic [COMBO_BITS-1:0] v
    );
        return (&v) ? v : v + COMBO_BITS'(1);
    endfunction

    judge_fifo #(
        .LANE_BITS (LANE_BITS),
        .CLOCK_BITS(CLOCK_BITS),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (push),
        .pop      (pop),
        .in_lane  (goal.goal_lane),
        .in_time  (goal.goal_time),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count),
        .head_lane(head_lane),
        .head_time(head_time)
    );

    assign run     = state == ST_RUN;
    assign busy    = run;
    assign done    = state == ST_DONE;
    assign restart = start && !abort && !run;
    assign flush   = abort || restart;

    assign goal.goal_ready = run && !full && !last_seen;
    assign push      = goal.goal_valid && goal.goal_ready;
    assign last_next = last_seen || (push && goal.goal_last);

    // d is signed: sign bit set means the goal is still ahead of now
    assign hit_eff   = hit | hit_pend;
    assign lane_mask = LANES'(1) << head_lane;
    assign head_hit  = |(hit_eff & lane_mask);
    assign d         = {1'b0, now} - {1'b0, head_time};
    assign abs_d     = d[CLOCK_BITS] ? -d : d;
    assign in_perf   = abs_d <= (CLOCK_BITS+1)'(PERFECT_WIN);
    assign in_good   = abs_d <= (CLOCK_BITS+1)'(GOOD_WIN);
    assign late      = !d[CLOCK_BITS] && !in_good;

    always_comb begin
        grade = GRADE_NONE;
        if (run && !empty) begin
            unique case (1'b1)
                head_hit && in_perf:             grade = GRADE_PERFECT;
                head_hit && in_good && !in_perf: grade = GRADE_GOOD;
                late:                            grade = GRADE_MISS;
                default:                         grade = GRADE_NONE;
            endcase
        end
    end

    assign pop        = grade != GRADE_NONE;
    assign consume    = (grade == GRADE_PERFECT || grade == GRADE_GOOD)
                        ? lane_mask : '0;
    assign unconsumed = hit_eff & ~consume;
    assign stray      = tick && strict_q && (|unconsumed);
    assign count_after = fifo_count + CW'(push) - CW'(pop);

    always_comb begin
        base = '0;
        if (grade == GRADE_PERFECT) begin
            base = (SCORE_BITS+1)'(BASE_PERFECT);
        end else if (grade == GRADE_GOOD) begin
            base = (SCORE_BITS+1)'(BASE_GOOD);
        end
        bonus = (combo > COMBO_BITS'(BONUS_CAP))
                ? (SCORE_BITS+1)'(BONUS_CAP)
                : (SCORE_BITS+1)'(combo);
        sum        = {1'b0, score} + base + bonus;
        score_next = sum[SCORE_BITS] ? '1 : sum[SCORE_BITS-1:0];
        combo_inc  = sat_inc(combo);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            strict_q    <= 1'b0;
            last_seen   <= 1'b0;
            hit_pend    <= '0;
            now         <= '0;
            judge_valid <= 1'b0;
            judge_grade <= '0;
            judge_lane  <= '0;
            score       <= '0;
            combo       <= '0;
            max_combo   <= '0;
            perfect_cnt <= '0;
            good_cnt    <= '0;
            miss_cnt    <= '0;
        end else begin
            judge_valid <= 1'b0;
            if (abort) begin
                state     <= ST_IDLE;
                last_seen <= 1'b0;
                hit_pend  <= '0;
            end else if (restart) begin
                state       <= ST_RUN;
                strict_q    <= strict;
                last_seen   <= 1'b0;
                hit_pend    <= '0;
                now         <= '0;
                score       <= '0;
                combo       <= '0;
                max_combo   <= '0;
                perfect_cnt <= '0;
                good_cnt    <= '0;
                miss_cnt    <= '0;
            end else if (run) begin
                if (tick) begin
                    now <= now + CLOCK_BITS'(1);
                end
                hit_pend  <= tick ? '0 : unconsumed;
                last_seen <= last_next;
                if (last_next && count_after == '0) begin
                    state <= ST_DONE;
                end
                if (pop) begin
                    judge_valid <= 1'b1;
                    judge_grade <= grade;
                    judge_lane  <= head_lane;
                end
                case (grade)
                    GRADE_PERFECT, GRADE_GOOD: begin
                        combo <= combo_inc;
                        score <= score_next;
                        if (combo_inc > max_combo) begin
                            max_combo <= combo_inc;
                        end
                        if (grade == GRADE_PERFECT) begin
                            perfect_cnt <= sat_inc(perfect_cnt);
                        end else begin
                            good_cnt <= sat_inc(good_cnt);
                        end
                    end
                    GRADE_MISS: begin
                        combo    <= '0;
                        miss_cnt <= sat_inc(miss_cnt);
                    end
                    default: ;
                endcase
                // a stray hit dropped at the tick outranks this cycle's grade
                if (stray) begin
                    combo <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_play_judge.sv
// Directed bench for play_judge: grading windows, expiry,
// chords, strict mode, backpressure, abort and reset.
module tb_play_judge;
    logic        clk = 1'b0;
    logic        rst, start, abort, strict, tick;
    logic [6:0]  hit;
    logic [19:0] now;
    logic        judge_valid;
    logic [1:0]  judge_grade;
    logic [2:0]  judge_lane;
    logic [20:0] score;
    logic [11:0] combo, max_combo, perfect_cnt, good_cnt, miss_cnt;
    logic        busy, done;
    int          checks = 0;
    int          errors = 0;

    play_judge_if #(.LANE_BITS(3), .CLOCK_BITS(20)) gif ();

    play_judge dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .strict(strict), .tick(tick), .goal(gif.slave), .hit(hit),
        .now(now), .judge_valid(judge_valid),
        .judge_grade(judge_grade), .judge_lane(judge_lane),
        .score(score), .combo(combo), .max_combo(max_combo),
        .perfect_cnt(perfect_cnt), .good_cnt(good_cnt),
        .miss_cnt(miss_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic s);
        strict = s;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

    task automatic push_goal(input logic [2:0] l, input logic [19:0] t,
                             input logic lst);
        gif.goal_valid = 1'b1;
        gif.goal_lane  = l;
        gif.goal_time  = t;
        gif.goal_last  = lst;
        cyc();
        gif.goal_valid = 1'b0;
        gif.goal_last  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
        end
        tick = 1'b0;
    endtask

    task automatic press(input logic [6:0] m);
        hit = m;
        cyc();
        hit = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        checks++; if (now !== 20'd0) begin errors++; $display("FAIL rst_now got %0d want 0", now); end
        checks++; if (score !== 21'd0) begin errors++; $display("FAIL rst_score got %0d want 0", score); end
        checks++; if ({busy, done, gif.goal_ready, judge_valid} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b want 0000", {busy, done, gif.goal_ready, judge_valid}); end
        checks++; if ({combo, max_combo, miss_cnt} !== 36'd0) begin errors++; $display("FAIL rst_counts got %h want 0", {combo, max_combo, miss_cnt}); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_grades();
        do_start(1'b0);
        checks++; if (busy !== 1'b1 || gif.goal_ready !== 1'b1) begin errors++; $display("FAIL g_run got busy=%0d ready=%0d want 1 1", busy, gif.goal_ready); end
        push_goal(3'd2, 20'd100, 1'b0);
        push_goal(3'd2, 20'd200, 1'b1);
        checks++; if (gif.goal_ready !== 1'b0) begin errors++; $display("FAIL g_ready_after_last got %0d want 0", gif.goal_ready); end
        ticks(105);
        press(7'b0000100);
        checks++; if ({judge_valid, judge_grade, judge_lane} !== {1'b1, 2'd1, 3'd2}) begin errors++; $display("FAIL g_perfect got v=%0d g=%0d l=%0d want 1 1 2", judge_valid, judge_grade, judge_lane); end
        checks++; if (score !== 21'd300) begin errors++; $display("FAIL g_score1 got %0d want 300", score); end
        ticks(115);
        press(7'b0000100);
        checks++; if ({judge_valid, judge_grade, judge_lane} !== {1'b1, 2'd2, 3'd2}) begin errors++; $display("FAIL g_good got v=%0d g=%0d l=%0d want 1 2 2", judge_valid, judge_grade, judge_lane); end
        checks++; if (score !== 21'd401) begin errors++; $display("FAIL g_score2 got %0d want 401", score); end
        checks++; if (combo !== 12'd2 || max_combo !== 12'd2) begin errors++; $display("FAIL g_combo got %0d/%0d want 2/2", combo, max_combo); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL g_done got done=%0d busy=%0d want 1 0", done, busy); end
        checks++; if (now !== 20'd220) begin errors++; $display("FAIL g_now got %0d want 220", now); end
    endtask

    task automatic test_expiry();
        do_start(1'b0);
        checks++; if (score !== 21'd0 || combo !== 12'd0 || now !== 20'd0) begin errors++; $display("FAIL x_clear got s=%0d c=%0d n=%0d want 0 0 0", score, combo, now); end
        push_goal(3'd0, 20'd20, 1'b0);
        push_goal(3'd0, 20'd50, 1'b0);
        ticks(20);
        press(7'b0000001);
        checks++; if (combo !== 12'd1) begin errors++; $display("FAIL x_combo1 got %0d want 1", combo); end
        ticks(55);
        checks++; if (judge_valid !== 1'b0) begin errors++; $display("FAIL x_edge24 got %0d want 0", judge_valid); end
        cyc();
        checks++; if ({judge_valid, judge_grade, judge_lane} !== {1'b1, 2'd3, 3'd0}) begin errors++; $display("FAIL x_miss got v=%0d g=%0d l=%0d want 1 3 0", judge_valid, judge_grade, judge_lane); end
        checks++; if (combo !== 12'd0 || miss_cnt !== 12'd1) begin errors++; $display("FAIL x_misscnt got c=%0d m=%0d want 0 1", combo, miss_cnt); end
        push_goal(3'd0, 20'd300, 1'b0);
        ticks(175);
        press(7'b0000001);
        checks++; if (judge_valid !== 1'b0) begin errors++; $display("FAIL x_early got %0d want 0", judge_valid); end
        ticks(26);
        cyc();
        checks++; if (good_cnt !== 12'd0 || perfect_cnt !== 12'd1) begin errors++; $display("FAIL x_pend_clear got g=%0d p=%0d want 0 1", good_cnt, perfect_cnt); end
        press(7'b0000001);
        checks++; if ({judge_valid, judge_grade} !== {1'b1, 2'd2}) begin errors++; $display("FAIL x_good_edge got v=%0d g=%0d want 1 2", judge_valid, judge_grade); end
        checks++; if (score !== 21'd400) begin errors++; $display("FAIL x_score got %0d want 400", score); end
        do_abort();
    endtask

    task automatic test_chord();
        do_start(1'b0);
        push_goal(3'd1, 20'd40, 1'b0);
        push_goal(3'd4, 20'd40, 1'b0);
        ticks(40);
        press(7'b0010010);
        checks++; if ({judge_valid, judge_grade, judge_lane} !== {1'b1, 2'd1, 3'd1}) begin errors++; $display("FAIL c_first got v=%0d g=%0d l=%0d want 1 1 1", judge_valid, judge_grade, judge_lane); end
        cyc();
        checks++; if ({judge_valid, judge_grade, judge_lane} !== {1'b1, 2'd1, 3'd4}) begin errors++; $display("FAIL c_second got v=%0d g=%0d l=%0d want 1 1 4", judge_valid, judge_grade, judge_lane); end
        checks++; if (combo !== 12'd2 || score !== 21'd601) begin errors++; $display("FAIL c_combo got c=%0d s=%0d want 2 601", combo, score); end
    endtask

    task automatic test_abort();
        push_goal(3'd3, 20'd500, 1'b0);
        abort = 1'b1;
        start = 1'b1;
        cyc();
        abort = 1'b0;
        start = 1'b0;
        checks++; if (busy !== 1'b0 || gif.goal_ready !== 1'b0) begin errors++; $display("FAIL a_idle got busy=%0d ready=%0d want 0 0", busy, gif.goal_ready); end
        checks++; if (score !== 21'd601 || perfect_cnt !== 12'd2) begin errors++; $display("FAIL a_hold got s=%0d p=%0d want 601 2", score, perfect_cnt); end
    endtask

    task automatic test_strict(input logic s, input logic [11:0] exp_combo);
        do_start(s);
        for (int k = 1; k <= 5; k++) begin
            push_goal(3'd0, 20'(10 * k), 1'b0);
            ticks(10);
            press(7'b0000001);
        end
        checks++; if (combo !== 12'd5 || score !== 21'd1510) begin errors++; $display("FAIL s%0d_build got c=%0d s=%0d want 5 1510", s, combo, score); end
        press(7'b1000000);
        ticks(1);
        checks++; if (combo !== exp_combo) begin errors++; $display("FAIL s%0d_stray got %0d want %0d", s, combo, exp_combo); end
        checks++; if (perfect_cnt !== 12'd5 || miss_cnt !== 12'd0 || max_combo !== 12'd5) begin errors++; $display("FAIL s%0d_counts got p=%0d m=%0d x=%0d want 5 0 5", s, perfect_cnt, miss_cnt, max_combo); end
        do_abort();
    endtask

    task automatic test_back_to_back();
        do_start(1'b0);
        push_goal(3'd0, 20'd10, 1'b0);
        push_goal(3'd0, 20'd10, 1'b0);
        push_goal(3'd0, 20'd20, 1'b0);
        push_goal(3'd0, 20'd30, 1'b0);
        checks++; if (gif.goal_ready !== 1'b0) begin errors++; $display("FAIL b_full got %0d want 0", gif.goal_ready); end
        ticks(35);
        cyc();
        checks++; if (judge_valid !== 1'b1 || gif.goal_ready !== 1'b1) begin errors++; $display("FAIL b_pop1 got v=%0d r=%0d want 1 1", judge_valid, gif.goal_ready); end
        push_goal(3'd0, 20'd40, 1'b0);
        checks++; if ({judge_valid, judge_grade} !== {1'b1, 2'd3} || miss_cnt !== 12'd2) begin errors++; $display("FAIL b_pushpop got v=%0d g=%0d m=%0d want 1 3 2", judge_valid, judge_grade, miss_cnt); end
        checks++; if (gif.goal_ready !== 1'b1) begin errors++; $display("FAIL b_occ3 got %0d want 1", gif.goal_ready); end
        push_goal(3'd0, 20'd50, 1'b0);
        checks++; if (gif.goal_ready !== 1'b0) begin errors++; $display("FAIL b_refull got %0d want 0", gif.goal_ready); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (now !== 20'd0 || miss_cnt !== 12'd0 || score !== 21'd0) begin errors++; $display("FAIL m_rst got n=%0d m=%0d s=%0d want 0 0 0", now, miss_cnt, score); end
        checks++; if ({busy, done, gif.goal_ready, judge_valid} !== 4'b0000) begin errors++; $display("FAIL m_rst_flags got %b want 0000", {busy, done, gif.goal_ready, judge_valid}); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        strict = 1'b0; tick = 1'b0; hit = '0;
        gif.goal_valid = 1'b0;
        gif.goal_lane  = '0;
        gif.goal_time  = '0;
        gif.goal_last  = 1'b0;
        test_reset();
        test_grades();
        test_expiry();
        test_chord();
        test_abort();
        test_strict(1'b1, 12'd0);
        test_strict(1'b0, 12'd5);
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
